ppm_decoder: RTL and testbench

Receive-side counterpart of the D-PPM LED encoder. It samples the photodetector output, detects pulse rising edges, and measures the clock-cycle gap between consecutive edges. Each gap is classified as a 0 bit or a 1 bit, and the bits are assembled LSB-first into a `PACKET_SIZE` word. The word is handed to the downstream packet consumer with a one-cycle `valid` pulse.

---
 rtl/ppm_decoder.sv | 123 ++++++++++++
 tb/tb_ppm_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ppm_decoder.sv
// ppm_decoder: D-PPM receiver. Measures the cycle gap between sensor rising
// edges, classifies each gap as a 0 or 1 bit and assembles packets LSB-first.
module ppm_decoder #(
  parameter int PACKET_SIZE   = 8,
  parameter int COUNTER_SIZE  = 8,
  parameter int INTERVAL_LOW  = 4,
  parameter int INTERVAL_HIGH = 8,
  parameter int TOLERANCE     = 1,
  parameter int ACTIVE_HIGH   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sensor,
  output logic [PACKET_SIZE-1:0] data,
  output logic                   valid,
  output logic                   error,
  output logic                   busy
);

  localparam int BIT_W = $clog2(PACKET_SIZE + 1);
  localparam logic [COUNTER_SIZE-1:0] TIMEOUT = COUNTER_SIZE'(INTERVAL_HIGH + 1 + TOLERANCE);
  localparam logic [COUNTER_SIZE-1:0] LO0 = COUNTER_SIZE'(INTERVAL_LOW + 1 - TOLERANCE);
  localparam logic [COUNTER_SIZE-1:0] HI0 = COUNTER_SIZE'(INTERVAL_LOW + 1 + TOLERANCE);
  localparam logic [COUNTER_SIZE-1:0] LO1 = COUNTER_SIZE'(INTERVAL_HIGH + 1 - TOLERANCE);
  localparam logic [COUNTER_SIZE-1:0] HI1 = COUNTER_SIZE'(INTERVAL_HIGH + 1 + TOLERANCE);
  localparam logic INVERT = (ACTIVE_HIGH == 0);

  typedef enum logic {IDLE, RECEIVE} state_t;

  state_t                  state, state_n;
  logic                    s1, s2, s3;
  logic                    edge_det;
  logic                    is_zero, is_one;
  logic [COUNTER_SIZE-1:0] cnt, cnt_n;
  logic [BIT_W-1:0]        bit_idx, bit_idx_n;
  logic [PACKET_SIZE-1:0]  shift, shift_n, data_n;
  logic                    valid_n, error_n;

  // Sensor is asynchronous: normalise polarity, then synchronise and keep one
  // history sample so a rising edge is seen exactly once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sensor ^ INVERT;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 & ~s3;
  assign is_zero  = (cnt >= LO0) && (cnt <= HI0);
  assign is_one   = (cnt >= LO1) && (cnt <= HI1);
  assign busy     = (state == RECEIVE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data    <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      data    <= data_n;
      valid   <= valid_n;
      error   <= error_n;
    end
  end

  // An edge in the timeout cycle wins over the timeout and is classified.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data;
    valid_n   = 1'b0;
    error_n   = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) begin
          state_n   = RECEIVE;
          cnt_n     = COUNTER_SIZE'(1);
          bit_idx_n = '0;
        end
      end
      RECEIVE: begin
        if (edge_det) begin
          cnt_n = COUNTER_SIZE'(1);
          if (is_zero || is_one) begin
            for (int i = 0; i < PACKET_SIZE; i++) begin
              if (bit_idx == BIT_W'(i)) shift_n[i] = is_one;
            end
            bit_idx_n = bit_idx + BIT_W'(1);
            if (bit_idx == BIT_W'(PACKET_SIZE - 1)) begin
              data_n  = shift_n;
              valid_n = 1'b1;
              state_n = IDLE;
            end
          end else begin
            error_n = 1'b1;
            state_n = IDLE;
          end
        end else if (cnt == TIMEOUT) begin
          error_n = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + COUNTER_SIZE'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ppm_decoder.sv
// tb_ppm_decoder: directed checks of the D-PPM decoder, one active-high
// instance and one active-low instance sharing a single stimulus source.
module tb_ppm_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       act = 1'b0;
  logic       sel = 1'b0;
  logic       sensor_a, sensor_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, error_a, busy_a;
  logic       valid_b, error_b, busy_b;

  int checks = 0;
  int errors = 0;
  int valid_a_cnt = 0, error_a_cnt = 0, busy_a_cycles = 0;
  int valid_b_cnt = 0, error_b_cnt = 0, both_cnt = 0;
  int v0, e0, b0;

  assign sensor_a = sel ? 1'b0 : act;
  assign sensor_b = sel ? ~act : 1'b1;

  always #5 clock = ~clock;

  ppm_decoder dut_a (
    .clock(clock), .reset(reset), .sensor(sensor_a),
    .data(data_a), .valid(valid_a), .error(error_a), .busy(busy_a)
  );

  ppm_decoder #(.ACTIVE_HIGH(0)) dut_b (
    .clock(clock), .reset(reset), .sensor(sensor_b),
    .data(data_b), .valid(valid_b), .error(error_b), .busy(busy_b)
  );

  always @(negedge clock) begin
    if (valid_a) valid_a_cnt++;
    if (error_a) error_a_cnt++;
    if (busy_a) busy_a_cycles++;
    if (valid_b) valid_b_cnt++;
    if (error_b) error_b_cnt++;
    if ((valid_a && error_a) || (valid_b && error_b)) both_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every edge is a one-cycle active pulse; gap g puts the next rise g cycles later.
  task automatic pulse();
    act = 1'b1;
    tick();
    act = 1'b0;
  endtask

  task automatic gapPulse(input int g);
    repeat (g - 1) tick();
    pulse();
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    pulse();
    for (int i = 0; i < 8; i++) gapPulse(value[i] ? 9 : 5);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    checkOutput("reset_data", data_a, 0);
    checkOutput("reset_valid", valid_a, 0);
    checkOutput("reset_error", error_a, 0);
    checkOutput("reset_busy", busy_a, 0);
    reset = 1'b0;
    repeat (3) tick();

    // Nominal A5: valid arrives 3 cycles after the last rise
    b0 = busy_a_cycles; v0 = valid_a_cnt; e0 = error_a_cnt;
    applyStimulus(8'hA5);
    tick();
    checkOutput("nom_busy_pre", busy_a, 1);
    checkOutput("nom_valid_pre", valid_a, 0);
    tick();
    checkOutput("nom_valid", valid_a, 1);
    checkOutput("nom_data", data_a, 8'hA5);
    checkOutput("nom_busy_end", busy_a, 0);
    tick();
    checkOutput("nom_valid_once", valid_a, 0);
    checkOutput("nom_busy_cycles", busy_a_cycles - b0, 56);
    checkOutput("nom_valid_cnt", valid_a_cnt - v0, 1);
    checkOutput("nom_no_error", error_a_cnt - e0, 0);
    repeat (4) tick();

    // Tolerance window edges 4,6,8,10 accepted
    pulse();
    gapPulse(4); gapPulse(6); gapPulse(8); gapPulse(10);
    gapPulse(5); gapPulse(9); gapPulse(4); gapPulse(10);
    repeat (2) tick();
    checkOutput("tol_valid", valid_a, 1);
    checkOutput("tol_data", data_a, 8'hAC);
    repeat (4) tick();

    e0 = error_a_cnt;
    pulse();
    gapPulse(5); gapPulse(5); gapPulse(7);
    repeat (2) tick();
    checkOutput("bad_gap_error", error_a, 1);
    checkOutput("bad_gap_valid", valid_a, 0);
    checkOutput("bad_gap_data", data_a, 8'hAC);
    checkOutput("bad_gap_busy", busy_a, 0);
    repeat (20) tick();
    checkOutput("bad_gap_err_cnt", error_a_cnt - e0, 1);

    // Timeout: error lands 11 cycles after the last rise's edge-detect cycle
    e0 = error_a_cnt;
    pulse();
    gapPulse(5); gapPulse(5); gapPulse(5);
    repeat (11) tick();
    checkOutput("tmo_early", error_a, 0);
    checkOutput("tmo_busy_early", busy_a, 1);
    tick();
    checkOutput("tmo_error", error_a, 1);
    checkOutput("tmo_busy", busy_a, 0);
    tick();
    checkOutput("tmo_error_once", error_a, 0);
    v0 = valid_a_cnt;
    applyStimulus(8'h3C);
    repeat (2) tick();
    checkOutput("tmo_next_valid", valid_a, 1);
    checkOutput("tmo_next_data", data_a, 8'h3C);
    checkOutput("tmo_err_cnt", error_a_cnt - e0, 1);
    repeat (4) tick();

    // Reset in the middle of a packet
    pulse();
    gapPulse(9); gapPulse(5); gapPulse(9); gapPulse(5);
    #3 reset = 1'b1;
    #1;
    checkOutput("mid_rst_data", data_a, 0);
    checkOutput("mid_rst_valid", valid_a, 0);
    checkOutput("mid_rst_error", error_a, 0);
    checkOutput("mid_rst_busy", busy_a, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    e0 = error_a_cnt;
    applyStimulus(8'h96);
    repeat (2) tick();
    checkOutput("post_rst_valid", valid_a, 1);
    checkOutput("post_rst_data", data_a, 8'h96);
    checkOutput("post_rst_no_err", error_a_cnt - e0, 0);
    repeat (4) tick();

    // Back-to-back: next start marker 5 cycles after the last FF rise
    v0 = valid_a_cnt; e0 = error_a_cnt;
    applyStimulus(8'hFF);
    repeat (2) tick();
    checkOutput("b2b_ff_valid", valid_a, 1);
    checkOutput("b2b_ff_data", data_a, 8'hFF);
    repeat (2) tick();
    pulse();
    for (int i = 0; i < 4; i++) gapPulse(5);
    checkOutput("b2b_hold_data", data_a, 8'hFF);
    checkOutput("b2b_hold_busy", busy_a, 1);
    for (int i = 0; i < 4; i++) gapPulse(5);
    repeat (2) tick();
    checkOutput("b2b_00_valid", valid_a, 1);
    checkOutput("b2b_00_data", data_a, 8'h00);
    repeat (4) tick();
    checkOutput("b2b_valid_cnt", valid_a_cnt - v0, 2);
    checkOutput("b2b_no_err", error_a_cnt - e0, 0);

    // Active-low sensor on the second instance
    sel = 1'b1;
    repeat (3) tick();
    v0 = valid_a_cnt;
    applyStimulus(8'hA5);
    repeat (2) tick();
    checkOutput("inv_valid", valid_b, 1);
    checkOutput("inv_data", data_b, 8'hA5);
    checkOutput("inv_a_quiet", valid_a_cnt - v0, 0);
    repeat (4) tick();

    // Stuck-active sensor after reset: one start marker, one timeout
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    checkOutput("stuck_rst_data", data_b, 0);
    repeat (2) tick();
    v0 = valid_b_cnt; e0 = error_b_cnt;
    act = 1'b1;
    repeat (50) tick();
    act = 1'b0;
    repeat (5) tick();
    checkOutput("stuck_err_cnt", error_b_cnt - e0, 1);
    checkOutput("stuck_valid_cnt", valid_b_cnt - v0, 0);
    checkOutput("stuck_busy", busy_b, 0);
    checkOutput("never_both", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
